// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the multiplier result serializer.
// Frame geometry is derived from the multiplier operand width N and beat width W.
package mul_pkg;

    localparam int N_DEF = 32;
    localparam int W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic bit shape_ok(input int n, input int w);
        return ((2 * n) % w) == 0;
    endfunction

    function automatic int beats_of(input int n, input int w);
        return (2 * n) / w;
    endfunction

    // A single-beat frame still needs a one-bit counter to stay legal.
    function automatic int cnt_w_of(input int n, input int w);
        return (beats_of(n, w) > 1) ? $clog2(beats_of(n, w)) : 1;
    endfunction

    localparam int BEATS = beats_of(N_DEF, W_DEF);
    localparam int CNT_W = cnt_w_of(N_DEF, W_DEF);

endpackage

// File: rtl/mul_result_serializer_if.sv
// Product-in / beat-out port bundle of the serializer.
// Both sides: a transfer happens on a rising edge where valid && ready; the
// sender holds its payload stable while valid is high and ready is low.
interface mul_result_serializer_if #(
    parameter int N = 32,
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] in_result;
    logic           in_ovf;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ovf;
    logic           busy;

    modport master (
        output in_valid, in_result, in_ovf, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_result, in_ovf, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ovf, busy
    );
endinterface

// File: rtl/mul_result_slot.sv
// One-entry holding register with a full flag; load and clear are never
// requested together by the serializer, load is given priority anyway.
module mul_result_slot #(
    parameter int DW = 65
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q,
    output logic          full
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/mul_result_serializer.sv
// Streams each 2N-bit product as W-bit beats, LSB first, with a last marker;
// a pending slot plus a last-beat bypass keeps consecutive frames gap-free.
module mul_result_serializer
    import mul_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    mul_result_serializer_if.slave  bus,
    output state_t                  state_dbg
);
    localparam int PW      = 2 * N;
    localparam int BEATS_L = beats_of(N, W);
    localparam int CW      = cnt_w_of(N, W);

    if (!shape_ok(N, W)) begin : g_shape_check
        $error("mul_result_serializer: 2*N must be a multiple of W");
    end

    state_t          state;
    logic [PW-1:0]   active;
    logic            active_ovf;
    logic [CW-1:0]   cnt;
    logic [PW:0]     pend_q;
    logic            pend_full;

    logic in_xfer;
    logic out_xfer;
    logic last_beat;
    logic frame_end;
    logic bypass;
    logic pend_load;
    logic pend_clear;

    // in_ready comes straight from a register, so out_ready never reaches it.
    assign bus.in_ready = !pend_full;
    assign in_xfer      = bus.in_valid && !pend_full;
    assign out_xfer     = (state == SEND) && bus.out_ready;
    assign last_beat    = (cnt == CW'(BEATS_L - 1));
    assign frame_end    = out_xfer && last_beat;
    assign bypass       = frame_end && !pend_full && in_xfer;
    assign pend_load    = (state == SEND) && in_xfer && !bypass;
    assign pend_clear   = frame_end && pend_full;

    mul_result_slot #(.DW(PW + 1)) u_pend (
        .clk   (clk),
        .reset (reset),
        .load  (pend_load),
        .clear (pend_clear),
        .d     ({bus.in_ovf, bus.in_result}),
        .q     (pend_q),
        .full  (pend_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            active     <= '0;
            active_ovf <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        active     <= bus.in_result;
                        active_ovf <= bus.in_ovf;
                        cnt        <= '0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (out_xfer) begin
                        if (!last_beat) begin
                            active <= active >> W;
                            cnt    <= cnt + CW'(1);
                        end else if (pend_full) begin
                            active     <= pend_q[PW-1:0];
                            active_ovf <= pend_q[PW];
                            cnt        <= '0;
                        end else if (in_xfer) begin
                            active     <= bus.in_result;
                            active_ovf <= bus.in_ovf;
                            cnt        <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = (state == SEND);
    assign bus.out_data  = active[W-1:0];
    assign bus.out_last  = last_beat && (state == SEND);
    assign bus.out_ovf   = active_ovf;
    assign bus.busy      = (state == SEND) || pend_full;
    assign state_dbg     = state;
endmodule

// File: tb/tb_mul_result_serializer.sv
// Self-checking bench: a product-level reference model fills an expected beat
// queue on each accepted product; directed scenarios add timing checks.
module tb_mul_result_serializer;
    import mul_pkg::*;

    localparam int N  = 32;
    localparam int W  = 8;
    localparam int NB = BEATS;

    logic   clk = 1'b0;
    logic   reset;
    state_t state_dbg;

    always #5 clk = ~clk;

    mul_result_serializer_if #(.N(N), .W(W)) bus ();

    mul_result_serializer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [W+1:0] exp_q[$];
    logic         prev_stall = 1'b0;
    logic [W+1:0] prev_beat  = '0;

    // Reference model: a product becomes NB beats {ovf, last, slice}, low slice first.
    function automatic void push_frame(input logic [2*N-1:0] p, input logic ovf);
        for (int b = 0; b < NB; b++) begin
            exp_q.push_back({ovf, (b == NB - 1), p[b*W +: W]});
        end
    endfunction

    // Scoreboard: observe both handshakes half a cycle before the edge they complete on.
    always @(negedge clk) begin
        logic [W+1:0] obs;
        logic [W+1:0] exp;
        obs = {bus.out_ovf, bus.out_last, bus.out_data};
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || obs !== prev_beat) begin
                    n_fail++;
                    $display("FAIL hold: got valid=%b beat=%h, need valid=1 beat=%h", bus.out_valid, obs, prev_beat);
                end
            end
            if (!bus.out_valid) begin
                n_checks++;
                if (bus.out_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_last: got out_last=%b, need 0", bus.out_last);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat: got unexpected beat %h, need no beat", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        n_fail++;
                        $display("FAIL beat: got {ovf,last,data}=%h, need %h", obs, exp);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) push_frame(bus.in_result, bus.in_ovf);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_beat  = obs;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_ovf    = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) break;
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got %0d beats left busy=%b, need 0 and 0", exp_q.size(), bus.busy);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_last, bus.out_ovf, bus.busy, bus.in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}
            || state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL reset: got valid=%b data=%h last=%b ovf=%b busy=%b in_ready=%b, need 0 00 0 0 0 1",
                     bus.out_valid, bus.out_data, bus.out_last, bus.out_ovf, bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_single_frame();
        logic [2*N-1:0] p;
        p = 64'h0123456789ABCDEF;
        tick();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_result = p;
        bus.in_ovf    = 1'b0;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_result = {$urandom, $urandom};
        bus.in_ovf    = 1'b1;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== p[k*W +: W] || bus.out_last !== (k == NB - 1)) begin
                n_fail++;
                $display("FAIL single_beat%0d: got valid=%b data=%h last=%b, need 1 %h %b",
                         k, bus.out_valid, bus.out_data, bus.out_last, p[k*W +: W], (k == NB - 1));
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: got valid=%b busy=%b, need 0 0", bus.out_valid, bus.busy);
        end
        tick();
    endtask

    task automatic test_back_pressure();
        logic [3:0] pat;
        int xfers;
        pat   = 4'b1001;
        xfers = 0;
        bus.in_valid  = 1'b1;
        bus.in_result = 64'h0123456789ABCDEF;
        bus.in_ovf    = 1'b0;
        bus.out_ready = pat[3];
        tick();
        bus.in_valid = 1'b0;
        for (int c = 1; c < 64; c++) begin
            bus.out_ready = pat[3 - (c % 4)];
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) xfers++;
            if (!bus.busy) break;
            tick();
        end
        n_checks++;
        if (xfers != NB) begin
            n_fail++;
            $display("FAIL bp_count: got %0d transfers, need %0d", xfers, NB);
        end
        tick();
    endtask

    task automatic test_pending_bypass();
        logic [2*N-1:0] a, b, c3;
        logic           exp_ovf;
        a  = 64'h1111111111111111;
        b  = 64'h2222222222222222;
        c3 = {$urandom, $urandom};
        bus.out_ready = 1'b1;
        for (int c = 0; c <= 25; c++) begin
            bus.in_valid  = (c == 0) || (c == 2) || (c == 16);
            bus.in_result = (c == 0) ? a : (c == 2) ? b : c3;
            bus.in_ovf    = (c == 0);
            @(negedge clk);
            n_checks++;
            if (bus.in_ready !== !(c >= 3 && c <= 8)) begin
                n_fail++;
                $display("FAIL pb_in_ready c=%0d: got %b, need %b", c, bus.in_ready, !(c >= 3 && c <= 8));
            end
            if (c >= 1 && c <= 24) begin
                exp_ovf = (c <= 8);
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_ovf !== exp_ovf) begin
                    n_fail++;
                    $display("FAIL pb_stream c=%0d: got valid=%b ovf=%b, need 1 %b", c, bus.out_valid, bus.out_ovf, exp_ovf);
                end
            end
            if (c == 25) begin
                n_checks++;
                if (bus.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pb_end: got valid=%b, need 0", bus.out_valid);
                end
            end
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_full_stall();
        logic [2*N-1:0] a;
        a = {$urandom, $urandom};
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = a;
        bus.in_ovf    = 1'b0;
        tick();
        bus.in_result = {$urandom, $urandom};
        bus.in_ovf    = 1'b1;
        tick();
        bus.in_result = {$urandom, $urandom};
        bus.in_ovf    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== a[W-1:0]) begin
                n_fail++;
                $display("FAIL stall: got in_ready=%b valid=%b data=%h, need 0 1 %h", bus.in_ready, bus.out_valid, bus.out_data, a[W-1:0]);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_drain%0d: got in_ready=%b, need 0", k, bus.in_ready);
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got in_ready=%b, need 1", bus.in_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_reset_mid_frame();
        logic [2*N-1:0] e;
        bus.out_ready = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            bus.in_valid  = (c <= 1);
            bus.in_result = {$urandom, $urandom};
            bus.in_ovf    = c[0];
            if (c == 4) begin
                @(negedge clk);
                n_checks++;
                if (bus.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_pend: got in_ready=%b, need 0", bus.in_ready);
                end
            end
            tick();
        end
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got valid=%b in_ready=%b busy=%b, need 0 1 0", bus.out_valid, bus.in_ready, bus.busy);
        end
        tick();
        e = {$urandom, $urandom};
        bus.in_valid  = 1'b1;
        bus.in_result = e;
        bus.in_ovf    = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e[W-1:0] || bus.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_restart: got valid=%b data=%h last=%b, need 1 %h 0", bus.out_valid, bus.out_data, bus.out_last, e[W-1:0]);
        end
        tick();
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = $urandom_range(0, 1);
            bus.in_result = {$urandom, $urandom};
            bus.in_ovf    = $urandom_range(0, 1);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_ovf    = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_back_pressure();
        test_pending_bypass();
        drain();
        test_full_stall();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
